// File: rtl/frame_config_writer.sv
// Bitstream word consumer for frame-configured tiles: hunts for a sync word, decodes
// frame headers, assembles one frame of row words and fires a one-hot frame strobe.
module frame_config_writer #(
    parameter int          NumRows         = 4,
    parameter int          NumCols         = 4,
    parameter int          MaxFramesPerCol = 20,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                               UserCLK,
    input  logic                               SR,
    input  logic [31:0]                        WordData,
    input  logic                               WordValid,
    output logic                               WordReady,
    output logic [NumRows*32-1:0]              FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                               Synced,
    output logic                               ConfigError,
    output logic [15:0]                        FramesWritten
);

    localparam int              CntW     = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int              StrobeW  = NumCols * MaxFramesPerCol;
    localparam logic [CntW-1:0] LastWord = CntW'(NumRows - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_HEADER,
        ST_DATA,
        ST_STROBE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic                 w_accept;
    logic                 w_is_sync;
    logic                 w_is_desync;
    logic                 w_hdr_bad;
    logic                 w_hdr_load;
    logic                 w_last_word;

    logic [7:0]           r_col;
    logic [7:0]           r_frame;
    logic [CntW-1:0]      r_word_cnt;
    logic                 r_skip;
    logic                 r_synced;
    logic                 r_config_error;
    logic [15:0]          r_frames_written;
    logic [StrobeW-1:0]   r_strobe;
    logic [StrobeW-1:0]   w_strobe_onehot;
    logic [31:0]          r_row [NumRows];

    // Word classification; only meaningful in the state that consumes the word.
    assign w_is_sync   = (WordData == SyncWord);
    assign w_is_desync = WordData[31];
    assign w_hdr_bad   = (32'(WordData[23:16]) >= 32'(NumCols)) ||
                         (32'(WordData[7:0])   >= 32'(MaxFramesPerCol));
    assign w_hdr_load  = w_accept && (r_state == ST_HEADER) && !w_is_sync && !w_is_desync;
    assign w_last_word = (r_word_cnt == LastWord);

    // State register
    always_ff @(posedge UserCLK) begin
        if (SR) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_accept && w_is_sync) begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_accept && !w_is_sync) begin
                    w_state_next = w_is_desync ? ST_HUNT : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_accept && w_last_word) begin
                    w_state_next = r_skip ? ST_HEADER : ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_state_next = ST_HEADER;
            end
            default: begin
                w_state_next = ST_HUNT;
            end
        endcase
    end

    // Output decode: ready is combinational from state and reads high while in reset.
    always_comb begin
        WordReady = SR || (r_state != ST_STROBE);
        w_accept  = WordValid && WordReady && !SR;
    end

    // Header latch, word counter, skip flag and sticky error
    always_ff @(posedge UserCLK) begin
        if (SR) begin
            r_col          <= '0;
            r_frame        <= '0;
            r_word_cnt     <= '0;
            r_skip         <= 1'b0;
            r_config_error <= 1'b0;
        end else if (w_hdr_load) begin
            r_col      <= WordData[23:16];
            r_frame    <= WordData[7:0];
            r_word_cnt <= '0;
            r_skip     <= w_hdr_bad;
            if (w_hdr_bad) begin
                r_config_error <= 1'b1;
            end
        end else if (w_accept && (r_state == ST_DATA)) begin
            r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
        end
    end

    // Registered status outputs and the frame counter
    always_ff @(posedge UserCLK) begin
        if (SR) begin
            r_synced         <= 1'b0;
            r_frames_written <= '0;
            r_strobe         <= '0;
        end else begin
            r_synced <= (w_state_next != ST_HUNT);
            r_strobe <= (w_state_next == ST_STROBE) ? w_strobe_onehot : '0;
            if (r_state == ST_STROBE) begin
                r_frames_written <= r_frames_written + 16'd1;
            end
        end
    end

    // One-hot decode of the latched column/frame address
    generate
        for (genvar gc = 0; gc < NumCols; gc++) begin : g_col
            for (genvar gf = 0; gf < MaxFramesPerCol; gf++) begin : g_frame
                assign w_strobe_onehot[gc*MaxFramesPerCol + gf] =
                    (r_col == 8'(gc)) && (r_frame == 8'(gf));
            end
        end
    endgenerate

    // Row slots: each non-skipped data word lands in the slot given by the word counter.
    generate
        for (genvar gi = 0; gi < NumRows; gi++) begin : g_row
            always_ff @(posedge UserCLK) begin
                if (SR) begin
                    r_row[gi] <= '0;
                end else if (w_accept && (r_state == ST_DATA) && !r_skip &&
                             (r_word_cnt == CntW'(gi))) begin
                    r_row[gi] <= WordData;
                end
            end
            assign FrameData[32*gi +: 32] = r_row[gi];
        end
    endgenerate

    assign FrameStrobe   = r_strobe;
    assign Synced        = r_synced;
    assign ConfigError   = r_config_error;
    assign FramesWritten = r_frames_written;

endmodule

// File: tb/tb_frame_config_writer.sv
// Scoreboard bench for frame_config_writer: a word-level reference model queues expected
// strobes, a monitor pops and compares them, and status outputs are checked per word.
module tb_frame_config_writer;

    localparam int          NR   = 4;
    localparam int          NC   = 4;
    localparam int          MF   = 20;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic               UserCLK = 1'b0;
    logic               SR = 1'b1;
    logic [31:0]        WordData = '0;
    logic               WordValid = 1'b0;
    logic               WordReady;
    logic [NR*32-1:0]   FrameData;
    logic [NC*MF-1:0]   FrameStrobe;
    logic               Synced;
    logic               ConfigError;
    logic [15:0]        FramesWritten;

    frame_config_writer #(
        .NumRows(NR), .NumCols(NC), .MaxFramesPerCol(MF), .SyncWord(SYNC)
    ) dut (
        .UserCLK(UserCLK), .SR(SR), .WordData(WordData), .WordValid(WordValid),
        .WordReady(WordReady), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .Synced(Synced), .ConfigError(ConfigError), .FramesWritten(FramesWritten)
    );

    always #5 UserCLK = ~UserCLK;

    typedef struct {
        int               idx;
        logic [NR*32-1:0] data;
        logic [15:0]      fw;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   gap = 0;

    // Reference model: what the stream means, word by word.
    bit               m_synced;
    bit               m_in_frame;
    bit               m_skip;
    bit               m_err;
    int               m_idx;
    int               m_count;
    logic [NR*32-1:0] m_fd;
    logic [15:0]      m_fw;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_in_frame = 0; m_skip = 0; m_err = 0;
        m_idx = 0; m_count = 0; m_fd = '0; m_fw = '0;
        q.delete();
    endtask

    function automatic bit model_accept(input logic [31:0] w);
        int col, fr;
        exp_t e;
        if (!m_synced) begin
            if (w == SYNC) m_synced = 1;
        end else if (!m_in_frame) begin
            if (w == SYNC) begin
                // resync word between frames is harmless
            end else if (w[31]) begin
                m_synced = 0;
            end else begin
                col = int'(w[23:16]);
                fr  = int'(w[7:0]);
                m_skip = (col >= NC) || (fr >= MF);
                if (m_skip) m_err = 1;
                m_idx = col * MF + fr;
                m_count = 0;
                m_in_frame = 1;
            end
        end else begin
            if (!m_skip) m_fd[32*m_count +: 32] = w;
            m_count++;
            if (m_count == NR) begin
                m_in_frame = 0;
                if (!m_skip) begin
                    m_fw = m_fw + 16'd1;
                    e.idx = m_idx; e.data = m_fd; e.fw = m_fw;
                    q.push_back(e);
                    return 1;
                end
            end
        end
        return 0;
    endfunction

    // Monitor: every strobe must match the head of the expected queue.
    initial begin
        exp_t             e;
        logic [NC*MF-1:0] vec;
        bit               fw_pending;
        logic [15:0]      fw_exp;
        fw_pending = 0;
        fw_exp = '0;
        forever begin
            @(negedge UserCLK);
            if (fw_pending) begin
                chk("frames_written_after_strobe", FramesWritten, fw_exp);
                fw_pending = 0;
            end
            if (!SR && FrameStrobe !== '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", FrameStrobe, 0);
                end else begin
                    e = q.pop_front();
                    vec = '0;
                    vec[e.idx] = 1'b1;
                    chk("strobe_vector", FrameStrobe, vec);
                    chk("strobe_frame_data", FrameData, e.data);
                    chk("strobe_word_ready", WordReady, 0);
                    fw_pending = 1;
                    fw_exp = e.fw;
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge after the word was accepted.
    task automatic send(input logic [31:0] w);
        int n;
        bit strobe_due;
        n = 0;
        WordData = w;
        WordValid = 1'b1;
        while (!WordReady && n < 8) begin
            @(negedge UserCLK);
            n++;
        end
        if (!WordReady) begin
            chk("ready_timeout", WordReady, 1);
            WordValid = 1'b0;
            return;
        end
        strobe_due = model_accept(w);
        @(negedge UserCLK);
        WordValid = 1'b0;
        chk("synced", Synced, m_synced);
        chk("config_error", ConfigError, m_err);
        chk("frame_data", FrameData, m_fd);
        if (strobe_due) chk("strobe_latency", (FrameStrobe != '0) && !WordReady, 1);
        repeat (gap) @(negedge UserCLK);
    endtask

    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3);
        send(hdr); send(d0); send(d1); send(d2); send(d3);
    endtask

    task automatic do_reset(input int cycles);
        SR = 1'b1;
        WordValid = 1'b1;
        WordData = $urandom;
        repeat (cycles) begin
            @(negedge UserCLK);
            chk("ready_during_reset", WordReady, 1);
        end
        SR = 1'b0;
        WordValid = 1'b0;
        model_reset();
        chk("reset_frame_data", FrameData, 0);
        chk("reset_frame_strobe", FrameStrobe, 0);
        chk("reset_synced", Synced, 0);
        chk("reset_config_error", ConfigError, 0);
        chk("reset_frames_written", FramesWritten, 0);
    endtask

    task automatic check_idle();
        repeat (3) @(negedge UserCLK);
        chk("idle_frames_written", FramesWritten, m_fw);
        chk("idle_frame_data", FrameData, m_fd);
        chk("idle_no_strobe", FrameStrobe, 0);
    endtask

    initial begin
        int r;
        logic [31:0] hdr;
        model_reset();
        @(negedge UserCLK);
        do_reset(2);

        // Basic frame: col 2, frame 5
        gap = 0;
        send(32'h1234_5678); send(SYNC);
        send_frame(32'h0002_0005, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check_idle();

        // Same stream, gapped
        do_reset(1);
        gap = 1;
        send(32'h1234_5678); send(SYNC);
        send_frame(32'h0002_0005, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check_idle();
        gap = 0;

        // Out-of-range header is skipped, next valid frame strobes bit 79
        send_frame(32'h0004_0000, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        check_idle();
        send_frame(32'h0003_0013, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        check_idle();

        // Desync, discarded words, resync, sync-in-header
        send(32'h8000_0000);
        send_frame(32'h0001_0001, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        send(SYNC); send(SYNC);
        send_frame(32'h0000_0000, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
        check_idle();

        // Reset mid-frame, then header without sync
        send(32'h0001_0002); send(32'hF0); send(32'hF1);
        do_reset(1);
        send_frame(32'h0001_0001, 32'h10, 32'h11, 32'h12, 32'h13);
        check_idle();

        // Randomised mix of frames, bad headers, desyncs and gaps
        for (int i = 0; i < 200; i++) begin
            gap = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send(32'h8000_0000 | ($urandom & 32'h7FFF_FFFF));
            end else if (r == 1) begin
                send(SYNC);
            end else if (r == 2) begin
                send($urandom);
            end else begin
                if (!m_synced) send(SYNC);
                hdr = $urandom & 32'h7F00_FF00;
                hdr[23:16] = 8'($urandom_range(0, NC));
                hdr[7:0]   = 8'($urandom_range(0, MF + 1));
                send_frame(hdr, $urandom, $urandom, $urandom, $urandom);
            end
        end
        gap = 0;
        check_idle();
        chk("missed_strobes", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
